// File: rtl/gpu_pkg.sv
// Shared encodings for the core stage, fetcher status and LSU status.
// Imported by the scheduler, ALU, LSU and fetcher so every unit agrees.
package gpu_pkg;

  // Core stage encodings, broadcast to every ALU, LSU and PC unit
  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  // Fetcher status encodings
  localparam logic [2:0] FETCHER_IDLE     = 3'b000;
  localparam logic [2:0] FETCHER_FETCHING = 3'b001;
  localparam logic [2:0] FETCHER_FETCHED  = 3'b010;

  // Per-lane LSU status encodings
  localparam logic [1:0] LSU_IDLE       = 2'b00;
  localparam logic [1:0] LSU_REQUESTING = 2'b01;
  localparam logic [1:0] LSU_WAITING    = 2'b10;
  localparam logic [1:0] LSU_DONE       = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = CORE_IDLE,
    S_FETCH   = CORE_FETCH,
    S_DECODE  = CORE_DECODE,
    S_REQUEST = CORE_REQUEST,
    S_WAIT    = CORE_WAIT,
    S_EXECUTE = CORE_EXECUTE,
    S_UPDATE  = CORE_UPDATE,
    S_DONE    = CORE_DONE
  } core_state_e;

  // True when an LSU lane still has a memory operation outstanding
  function automatic logic lsu_busy(input logic [1:0] st);
    return (st == LSU_REQUESTING) || (st == LSU_WAITING);
  endfunction

endpackage

// File: rtl/core_scheduler.sv
// Block-level instruction sequencer for one compute core: steps all thread
// lanes through fetch/decode/request/wait/execute/update in lockstep, tracks
// the shared PC and flags lane divergence. All outputs come from registers.
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [THREADS_PER_BLOCK-1:0]   thread_enable,
  input  logic [2:0]                     fetcher_state,
  input  logic [2*THREADS_PER_BLOCK-1:0] lsu_state,
  input  logic                           decoded_ret,
  input  logic [8*THREADS_PER_BLOCK-1:0] next_pc,
  output logic [2:0]                     core_state,
  output logic [7:0]                     current_pc,
  output logic                           done,
  output logic                           diverged
);

  core_state_e state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic        done_q, done_d;
  logic        div_q, div_d;

  logic        mem_busy;
  logic        any_en;
  logic [7:0]  first_pc;
  logic        lanes_differ;

  // Lane reductions: outstanding memory, first enabled PC, divergence.
  // Comparing every enabled lane to the first enabled one is equivalent
  // to a pairwise compare.
  always_comb begin
    logic [1:0] lane_lsu;
    logic [7:0] lane_pc;
    mem_busy     = 1'b0;
    any_en       = 1'b0;
    first_pc     = '0;
    lanes_differ = 1'b0;
    lane_lsu     = '0;
    lane_pc      = '0;
    for (int unsigned i = 0; i < THREADS_PER_BLOCK; i++) begin
      lane_lsu = lsu_state[2*i +: 2];
      lane_pc  = next_pc[8*i +: 8];
      if (thread_enable[i]) begin
        if (lsu_busy(lane_lsu)) mem_busy = 1'b1;
        if (!any_en) begin
          first_pc = lane_pc;
          any_en   = 1'b1;
        end else if (lane_pc != first_pc) begin
          lanes_differ = 1'b1;
        end
      end
    end
  end

  // Next-state, PC, done and divergence logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    div_d   = div_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          div_d   = 1'b0;
        end
      end
      S_FETCH: begin
        if (fetcher_state == FETCHER_FETCHED) state_d = S_DECODE;
      end
      S_DECODE:  state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT: begin
        if (!mem_busy) state_d = S_EXECUTE;
      end
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE: begin
        if (lanes_differ) div_d = 1'b1;
        if (decoded_ret) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_FETCH;
          pc_d    = any_en ? first_pc : pc_q + 8'd1;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      div_q   <= div_d;
    end
  end

  assign core_state = state_q;
  assign current_pc = pc_q;
  assign done       = done_q;
  assign diverged   = div_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Self-checking bench for core_scheduler: directed scenarios followed by
// randomized blocks, compared against an instruction-level expected trace.
module tb_core_scheduler;
  import gpu_pkg::*;

  localparam int T = 4;

  logic           clock;
  logic           reset_n;
  logic           start;
  logic [T-1:0]   thread_enable;
  logic [2:0]     fetcher_state;
  logic [2*T-1:0] lsu_state;
  logic           decoded_ret;
  logic [8*T-1:0] next_pc;
  logic [2:0]     core_state;
  logic [7:0]     current_pc;
  logic           done;
  logic           diverged;

  core_scheduler #(.THREADS_PER_BLOCK(T)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .thread_enable (thread_enable),
    .fetcher_state (fetcher_state),
    .lsu_state     (lsu_state),
    .decoded_ret   (decoded_ret),
    .next_pc       (next_pc),
    .core_state    (core_state),
    .current_pc    (current_pc),
    .done          (done),
    .diverged      (diverged)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model state: PC and sticky divergence as seen by the instruction stream
  logic [7:0] m_pc;
  logic       m_div;
  logic [7:0] lane_pc [T];

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input logic [2:0] es, input logic [7:0] ep, input logic ed, input logic edv);
    check_val("core_state", 32'(core_state), 32'(es));
    check_val("current_pc", 32'(current_pc), 32'(ep));
    check_val("done",       32'(done),       32'(ed));
    check_val("diverged",   32'(diverged),   32'(edv));
  endtask

  task automatic step(input logic [2:0] es, input logic [7:0] ep, input logic ed, input logic edv);
    @(posedge clock);
    #1;
    check_all(es, ep, ed, edv);
  endtask

  task automatic apply_pcs();
    for (int i = 0; i < T; i++) next_pc[8*i +: 8] = lane_pc[i];
  endtask

  // Disabled lanes always look busy (must be ignored); the chosen lane is
  // busy when requested; other enabled lanes are idle or done.
  task automatic set_lsu(input int bl, input bit busy_on);
    for (int i = 0; i < T; i++) begin
      if (!thread_enable[i])
        lsu_state[2*i +: 2] = LSU_WAITING;
      else if (i == bl && busy_on)
        lsu_state[2*i +: 2] = ($urandom_range(0, 1) != 0) ? LSU_WAITING : LSU_REQUESTING;
      else
        lsu_state[2*i +: 2] = ($urandom_range(0, 1) != 0) ? LSU_DONE : LSU_IDLE;
    end
  endtask

  // One instruction, starting with the DUT already in FETCH.
  task automatic run_instr(input int fl, input int bl, input int busy, input bit ret,
                           input bit rand_pcs, input bit abort);
    int n;
    int first;
    logic [7:0] base;
    fetcher_state = FETCHER_FETCHING;
    decoded_ret   = 1'($urandom_range(0, 1));
    set_lsu(bl, 1'b0);
    for (int k = 0; k < fl; k++) step(CORE_FETCH, m_pc, 1'b0, m_div);
    fetcher_state = FETCHER_FETCHED;
    step(CORE_DECODE, m_pc, 1'b0, m_div);
    fetcher_state = FETCHER_IDLE;
    step(CORE_REQUEST, m_pc, 1'b0, m_div);
    step(CORE_WAIT, m_pc, 1'b0, m_div);
    set_lsu(bl, 1'b1);
    n = thread_enable[bl] ? busy : 0;
    for (int k = 0; k < n; k++) begin
      step(CORE_WAIT, m_pc, 1'b0, m_div);
      if (abort) begin
        #2 reset_n = 1'b0;
        #1 check_all(CORE_IDLE, 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        m_pc  = 8'h00;
        m_div = 1'b0;
        set_lsu(bl, 1'b0);
        step(CORE_FETCH, m_pc, 1'b0, m_div);
        return;
      end
    end
    set_lsu(bl, 1'b0);
    step(CORE_EXECUTE, m_pc, 1'b0, m_div);
    step(CORE_UPDATE, m_pc, 1'b0, m_div);
    if (rand_pcs) begin
      base = 8'($urandom);
      for (int i = 0; i < T; i++)
        lane_pc[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : base;
    end
    apply_pcs();
    decoded_ret = ret;
    // Divergence: any pair of enabled lanes with different targets
    for (int i = 0; i < T; i++)
      for (int j = 0; j < T; j++)
        if (thread_enable[i] && thread_enable[j] && lane_pc[i] != lane_pc[j]) m_div = 1'b1;
    if (ret) begin
      step(CORE_DONE, m_pc, 1'b1, m_div);
    end else begin
      first = -1;
      for (int i = T - 1; i >= 0; i--) if (thread_enable[i]) first = i;
      m_pc = (first < 0) ? 8'(m_pc + 8'd1) : lane_pc[first];
      step(CORE_FETCH, m_pc, 1'b0, m_div);
    end
    decoded_ret = 1'b0;
  endtask

  // From DONE: hold start, drop it, idle a while, restart into FETCH.
  task automatic finish_block(input int hold, input int idle);
    for (int k = 0; k < hold; k++) step(CORE_DONE, m_pc, 1'b1, m_div);
    start = 1'b0;
    step(CORE_IDLE, m_pc, 1'b0, m_div);
    for (int k = 0; k < idle; k++) step(CORE_IDLE, m_pc, 1'b0, m_div);
    start = 1'b1;
    m_pc  = 8'h00;
    m_div = 1'b0;
    step(CORE_FETCH, m_pc, 1'b0, m_div);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ninstr;
    reset_n       = 1'b0;
    start         = 1'b1;
    thread_enable = 4'b0001;
    fetcher_state = FETCHER_IDLE;
    lsu_state     = '0;
    decoded_ret   = 1'b0;
    next_pc       = '0;
    for (int i = 0; i < T; i++) lane_pc[i] = 8'h00;
    m_pc  = 8'h00;
    m_div = 1'b0;

    // Reset state, then first edge with start already high goes to FETCH
    #22;
    check_all(CORE_IDLE, 8'h00, 1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    step(CORE_FETCH, 8'h00, 1'b0, 1'b0);

    // Single lane, 2-cycle fetch, next_pc=0x01
    for (int i = 0; i < T; i++) lane_pc[i] = 8'h01;
    run_instr(1, 0, 0, 1'b0, 1'b0, 1'b0);

    // Lane1 holding memory for 5 cycles, then same with lane1 disabled
    thread_enable = 4'b0011;
    run_instr(0, 1, 5, 1'b0, 1'b1, 1'b0);
    thread_enable = 4'b0001;
    run_instr(0, 1, 5, 1'b0, 1'b1, 1'b0);

    // Divergent lanes 1 and 3; sticky through the next instruction and RET
    thread_enable = 4'b1010;
    lane_pc[0] = 8'h77; lane_pc[1] = 8'h10; lane_pc[2] = 8'h55; lane_pc[3] = 8'h12;
    run_instr(0, 0, 0, 1'b0, 1'b0, 1'b0);
    lane_pc[1] = 8'h20; lane_pc[3] = 8'h20;
    run_instr(2, 3, 1, 1'b0, 1'b0, 1'b0);
    run_instr(0, 0, 0, 1'b1, 1'b0, 1'b0);
    finish_block(2, 1);

    // PC wrap: via next_pc and via the no-lane increment
    thread_enable = 4'b0001;
    lane_pc[0] = 8'hFF;
    run_instr(0, 0, 0, 1'b0, 1'b0, 1'b0);
    lane_pc[0] = 8'h00;
    run_instr(0, 0, 0, 1'b0, 1'b0, 1'b0);
    lane_pc[0] = 8'hFF;
    run_instr(0, 0, 0, 1'b0, 1'b0, 1'b0);
    thread_enable = 4'b0000;
    run_instr(1, 2, 2, 1'b0, 1'b1, 1'b0);

    // Reset asynchronously in the middle of WAIT
    thread_enable = 4'b0001;
    run_instr(1, 0, 3, 1'b0, 1'b1, 1'b1);

    // Randomized blocks
    for (int b = 0; b < 25; b++) begin
      thread_enable = 4'($urandom_range(0, 15));
      ninstr = $urandom_range(1, 5);
      for (int k = 0; k < ninstr; k++)
        run_instr($urandom_range(0, 3), $urandom_range(0, T - 1), $urandom_range(0, 4),
                  k == ninstr - 1, 1'b1, 1'b0);
      finish_block($urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
